hazard_ctrl: RTL and testbench

Parametrised pipeline hazard controller for the five-stage RISC-V core. It drives the per-stage enables and flushes of the IF/ID, ID/EX, EX/MEM and MEM/WB registers, which the current top ties permanently to 1. It produces the EX operand-forwarding selects and freezes the whole pipeline for multi-cycle memory accesses. It also keeps stall and flush performance counters.

---
 rtl/hazard_ctrl.sv | 153 +++++++++++++++
 tb/tb_hazard_ctrl.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the five-stage core.
// Produces per-stage enables/flushes, EX forwarding selects, a multi-cycle
// memory freeze FSM, and stall/flush performance counters.
module hazard_ctrl #(
  parameter int REG_AW  = 5,
  parameter int MEM_LAT = 1,
  parameter int FWD_EN  = 1
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic [REG_AW-1:0] i_rs1_id,
  input  logic [REG_AW-1:0] i_rs2_id,
  input  logic              i_rs1_use_id,
  input  logic              i_rs2_use_id,
  input  logic [REG_AW-1:0] i_rs1_ex,
  input  logic [REG_AW-1:0] i_rs2_ex,
  input  logic [REG_AW-1:0] i_rd_ex,
  input  logic              i_rd_wren_ex,
  input  logic              i_is_load_ex,
  input  logic              i_pc_sel_ex,
  input  logic [REG_AW-1:0] i_rd_mem,
  input  logic              i_rd_wren_mem,
  input  logic              i_mem_req_mem,
  input  logic [REG_AW-1:0] i_rd_wb,
  input  logic              i_rd_wren_wb,
  output logic              o_enable_pc,
  output logic              o_enable_if,
  output logic              o_enable_id,
  output logic              o_enable_ex,
  output logic              o_enable_mem,
  output logic              o_reset_if,
  output logic              o_reset_id,
  output logic              o_reset_ex,
  output logic              o_reset_mem,
  output logic [1:0]        o_fwd_a_sel,
  output logic [1:0]        o_fwd_b_sel,
  output logic [31:0]       o_stall_cnt,
  output logic [31:0]       o_flush_cnt
);

  typedef enum logic {RUN, WAIT} state_t;

  // A latency of 1 never freezes; otherwise the wait counter starts at MEM_LAT-2.
  localparam bit          LONG_MEM = (MEM_LAT > 1);
  localparam logic [3:0]  CNT_INIT = 4'((MEM_LAT > 1) ? (MEM_LAT - 2) : 0);
  localparam bit          FWD      = (FWD_EN != 0);

  state_t      r_state;
  logic [3:0]  r_cnt;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;

  logic w_freeze;
  logic w_match_ex;
  logic w_match_mem;
  logic w_stall;
  logic w_flush_take;

  // x0 is never a real producer, so it never matches.
  function automatic logic f_match(input logic u, input logic [REG_AW-1:0] src,
                                   input logic wren, input logic [REG_AW-1:0] rd);
    return u && (src != '0) && wren && (src == rd);
  endfunction

  function automatic logic [1:0] f_fwd(input logic [REG_AW-1:0] src);
    if (!FWD)                                         return 2'b00;
    else if (f_match(1'b1, src, i_rd_wren_mem, i_rd_mem)) return 2'b01;
    else if (f_match(1'b1, src, i_rd_wren_wb, i_rd_wb))   return 2'b10;
    else                                              return 2'b00;
  endfunction

  assign w_freeze    = (r_state == RUN) ? (i_mem_req_mem && LONG_MEM) : (r_cnt != 4'd0);
  assign w_match_ex  = f_match(i_rs1_use_id, i_rs1_id, i_rd_wren_ex, i_rd_ex) ||
                       f_match(i_rs2_use_id, i_rs2_id, i_rd_wren_ex, i_rd_ex);
  assign w_match_mem = f_match(i_rs1_use_id, i_rs1_id, i_rd_wren_mem, i_rd_mem) ||
                       f_match(i_rs2_use_id, i_rs2_id, i_rd_wren_mem, i_rd_mem);
  assign w_stall     = FWD ? (i_is_load_ex && w_match_ex) : (w_match_ex || w_match_mem);

  assign o_fwd_a_sel = f_fwd(i_rs1_ex);
  assign o_fwd_b_sel = f_fwd(i_rs2_ex);
  assign o_stall_cnt = r_stall_cnt;
  assign o_flush_cnt = r_flush_cnt;

  // Enable/flush priority: reset, freeze, redirect, data stall, run.
  always_comb begin
    o_enable_pc  = 1'b1;
    o_enable_if  = 1'b1;
    o_enable_id  = 1'b1;
    o_enable_ex  = 1'b1;
    o_enable_mem = 1'b1;
    o_reset_if   = 1'b1;
    o_reset_id   = 1'b1;
    o_reset_ex   = 1'b1;
    o_reset_mem  = 1'b1;
    w_flush_take = 1'b0;
    if (!i_reset) begin
      o_enable_pc  = 1'b0;
      o_enable_if  = 1'b0;
      o_enable_id  = 1'b0;
      o_enable_ex  = 1'b0;
      o_enable_mem = 1'b0;
      o_reset_if   = 1'b0;
      o_reset_id   = 1'b0;
      o_reset_ex   = 1'b0;
      o_reset_mem  = 1'b0;
    end else if (w_freeze) begin
      // Redirect is held in the frozen ID/EX register and handled at unfreeze.
      o_enable_pc  = 1'b0;
      o_enable_if  = 1'b0;
      o_enable_id  = 1'b0;
      o_enable_ex  = 1'b0;
      o_enable_mem = 1'b0;
    end else if (i_pc_sel_ex) begin
      o_reset_if   = 1'b0;
      o_reset_id   = 1'b0;
      w_flush_take = 1'b1;
    end else if (w_stall) begin
      o_enable_pc  = 1'b0;
      o_enable_if  = 1'b0;
      o_reset_id   = 1'b0;
    end
  end

  // Memory-latency FSM: RUN freezes on a long op and hands off to WAIT.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= RUN;
      r_cnt   <= 4'd0;
    end else begin
      case (r_state)
        RUN: if (i_mem_req_mem && LONG_MEM) begin
          r_state <= WAIT;
          r_cnt   <= CNT_INIT;
        end
        WAIT: if (r_cnt != 4'd0) r_cnt <= r_cnt - 4'd1;
              else               r_state <= RUN;
        default: r_state <= RUN;
      endcase
    end
  end

  // Performance counters, free-running with natural 32-bit wrap.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      r_stall_cnt <= 32'd0;
      r_flush_cnt <= 32'd0;
    end else begin
      if (!o_enable_pc) r_stall_cnt <= r_stall_cnt + 32'd1;
      if (w_flush_take) r_flush_cnt <= r_flush_cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: dut0 forwards with MEM_LAT=4,
// dut1 has forwarding disabled with MEM_LAT=1. Both share one input set.
module tb_hazard_ctrl;
  localparam logic [4:0] EN_ALL = 5'b11111, EN_STL = 5'b00111, EN_0 = 5'b00000;
  localparam logic [3:0] RS_ALL = 4'b1111,  RS_RED = 4'b0011,  RS_STL = 4'b1011, RS_0 = 4'b0000;

  typedef struct {
    int          dut;
    string       name;
    logic [4:0]  en;
    logic [3:0]  rs;
    logic [1:0]  fa, fb;
    logic [31:0] sc, fc;
  } exp_t;

  logic clk = 1'b0;
  logic rstn;
  logic [4:0] rs1_id, rs2_id, rs1_ex, rs2_ex, rd_ex, rd_mem, rd_wb;
  logic u1, u2, wr_ex, ld_ex, pcsel, wr_mem, mreq, wr_wb;

  logic [4:0]  en   [2];
  logic [3:0]  rs   [2];
  logic [1:0]  fa   [2], fb [2];
  logic [31:0] sc   [2], fc [2];

  exp_t        q[$];
  logic [31:0] m_stall [2];
  logic [31:0] m_flush [2];
  int          napplied = 0;
  int          miscompares = 0;

  always #5 clk = ~clk;

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(4), .FWD_EN(1)) u_dut0 (
    .i_clk(clk), .i_reset(rstn),
    .i_rs1_id(rs1_id), .i_rs2_id(rs2_id), .i_rs1_use_id(u1), .i_rs2_use_id(u2),
    .i_rs1_ex(rs1_ex), .i_rs2_ex(rs2_ex), .i_rd_ex(rd_ex), .i_rd_wren_ex(wr_ex),
    .i_is_load_ex(ld_ex), .i_pc_sel_ex(pcsel),
    .i_rd_mem(rd_mem), .i_rd_wren_mem(wr_mem), .i_mem_req_mem(mreq),
    .i_rd_wb(rd_wb), .i_rd_wren_wb(wr_wb),
    .o_enable_pc(en[0][4]), .o_enable_if(en[0][3]), .o_enable_id(en[0][2]),
    .o_enable_ex(en[0][1]), .o_enable_mem(en[0][0]),
    .o_reset_if(rs[0][3]), .o_reset_id(rs[0][2]), .o_reset_ex(rs[0][1]), .o_reset_mem(rs[0][0]),
    .o_fwd_a_sel(fa[0]), .o_fwd_b_sel(fb[0]),
    .o_stall_cnt(sc[0]), .o_flush_cnt(fc[0])
  );

  hazard_ctrl #(.REG_AW(5), .MEM_LAT(1), .FWD_EN(0)) u_dut1 (
    .i_clk(clk), .i_reset(rstn),
    .i_rs1_id(rs1_id), .i_rs2_id(rs2_id), .i_rs1_use_id(u1), .i_rs2_use_id(u2),
    .i_rs1_ex(rs1_ex), .i_rs2_ex(rs2_ex), .i_rd_ex(rd_ex), .i_rd_wren_ex(wr_ex),
    .i_is_load_ex(ld_ex), .i_pc_sel_ex(pcsel),
    .i_rd_mem(rd_mem), .i_rd_wren_mem(wr_mem), .i_mem_req_mem(mreq),
    .i_rd_wb(rd_wb), .i_rd_wren_wb(wr_wb),
    .o_enable_pc(en[1][4]), .o_enable_if(en[1][3]), .o_enable_id(en[1][2]),
    .o_enable_ex(en[1][1]), .o_enable_mem(en[1][0]),
    .o_reset_if(rs[1][3]), .o_reset_id(rs[1][2]), .o_reset_ex(rs[1][1]), .o_reset_mem(rs[1][0]),
    .o_fwd_a_sel(fa[1]), .o_fwd_b_sel(fb[1]),
    .o_stall_cnt(sc[1]), .o_flush_cnt(fc[1])
  );

  task automatic idle();
    rs1_id = 0; rs2_id = 0; u1 = 0; u2 = 0;
    rs1_ex = 0; rs2_ex = 0; rd_ex = 0; wr_ex = 0; ld_ex = 0; pcsel = 0;
    rd_mem = 0; wr_mem = 0; mreq = 0; rd_wb = 0; wr_wb = 0;
  endtask

  // Push the hand-computed response for the inputs just driven, then advance.
  // Counter expectations lag one cycle behind the enables that cause them.
  task automatic chk(input int d, input string name, input logic [4:0] e_en,
                     input logic [3:0] e_rs, input logic [1:0] e_fa, input logic [1:0] e_fb);
    exp_t e;
    e.dut = d; e.name = name; e.en = e_en; e.rs = e_rs; e.fa = e_fa; e.fb = e_fb;
    if (!rstn) begin
      for (int k = 0; k < 2; k++) begin m_stall[k] = 0; m_flush[k] = 0; end
      e.sc = 0; e.fc = 0;
    end else begin
      e.sc = m_stall[d]; e.fc = m_flush[d];
      if (!e_en[4]) m_stall[d] = m_stall[d] + 32'd1;
      if (!e_rs[3]) m_flush[d] = m_flush[d] + 32'd1;
    end
    q.push_back(e);
    @(posedge clk); #1;
  endtask

  // Monitor: outputs are combinational, so one response per cycle at negedge.
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      napplied++;
      if (en[e.dut] !== e.en || rs[e.dut] !== e.rs || fa[e.dut] !== e.fa ||
          fb[e.dut] !== e.fb || sc[e.dut] !== e.sc || fc[e.dut] !== e.fc) begin
        miscompares++;
        $display("FAIL %s dut%0d: got en=%b rs=%b fa=%b fb=%b sc=%h fc=%h, want en=%b rs=%b fa=%b fb=%b sc=%h fc=%h",
                 e.name, e.dut, en[e.dut], rs[e.dut], fa[e.dut], fb[e.dut], sc[e.dut], fc[e.dut],
                 e.en, e.rs, e.fa, e.fb, e.sc, e.fc);
      end
    end
  end

  initial begin
    int guard;
    for (int k = 0; k < 2; k++) begin m_stall[k] = 0; m_flush[k] = 0; end
    rstn = 0; idle();
    @(posedge clk); #1;

    // Reset
    chk(0, "rst0", EN_0, RS_0, 2'b00, 2'b00);
    chk(0, "rst1", EN_0, RS_0, 2'b00, 2'b00);
    chk(0, "rst2", EN_0, RS_0, 2'b00, 2'b00);
    rstn = 1;
    chk(0, "post_rst", EN_ALL, RS_ALL, 2'b00, 2'b00);

    // Load-use on x5: one stall, then dependent sees load in WB
    idle(); ld_ex = 1; rd_ex = 5; wr_ex = 1; rs1_id = 5; u1 = 1;
    chk(0, "lu_stall", EN_STL, RS_STL, 2'b00, 2'b00);
    idle(); rd_mem = 5; wr_mem = 1; rs1_id = 5; u1 = 1;
    chk(0, "lu_bubble", EN_ALL, RS_ALL, 2'b00, 2'b00);
    idle(); rd_wb = 5; wr_wb = 1; rs1_ex = 5;
    chk(0, "lu_fwd_wb", EN_ALL, RS_ALL, 2'b10, 2'b00);
    idle(); ld_ex = 1; rd_ex = 0; wr_ex = 1; rs1_id = 0; u1 = 1;
    chk(0, "lu_x0", EN_ALL, RS_ALL, 2'b00, 2'b00);
    idle(); ld_ex = 1; rd_ex = 5; wr_ex = 1; rs1_id = 5; u1 = 0;
    chk(0, "lu_nouse", EN_ALL, RS_ALL, 2'b00, 2'b00);
    idle(); rd_ex = 4; wr_ex = 1; rs2_id = 4; u2 = 1;
    chk(0, "alu_dep_fwd", EN_ALL, RS_ALL, 2'b00, 2'b00);

    // Forwarding priority
    idle(); rd_mem = 7; wr_mem = 1; rd_wb = 7; wr_wb = 1; rs1_ex = 7; rs2_ex = 3;
    chk(0, "fwd_mem", EN_ALL, RS_ALL, 2'b01, 2'b00);
    wr_mem = 0; rs2_ex = 7;
    chk(0, "fwd_wb", EN_ALL, RS_ALL, 2'b10, 2'b10);

    // Memory freeze, redirect pending during freeze
    idle(); mreq = 1; rd_wb = 7; wr_wb = 1; rs1_ex = 7;
    chk(0, "frz1", EN_0, RS_ALL, 2'b10, 2'b00);
    pcsel = 1;
    chk(0, "frz2", EN_0, RS_ALL, 2'b10, 2'b00);
    chk(0, "frz3", EN_0, RS_ALL, 2'b10, 2'b00);
    chk(0, "unfrz_redirect", EN_ALL, RS_RED, 2'b10, 2'b00);
    idle();
    chk(0, "after_frz", EN_ALL, RS_ALL, 2'b00, 2'b00);

    // Stall counter wrap
    force u_dut0.r_stall_cnt = 32'hFFFF_FFFF;
    #1;
    release u_dut0.r_stall_cnt;
    m_stall[0] = 32'hFFFF_FFFF;
    chk(0, "wrap_pre", EN_ALL, RS_ALL, 2'b00, 2'b00);
    idle(); ld_ex = 1; rd_ex = 9; wr_ex = 1; rs2_id = 9; u2 = 1;
    chk(0, "wrap_stall", EN_STL, RS_STL, 2'b00, 2'b00);
    idle();
    chk(0, "wrap_zero", EN_ALL, RS_ALL, 2'b00, 2'b00);

    // Reset in the middle of WAIT
    idle(); mreq = 1;
    chk(0, "rw_frz1", EN_0, RS_ALL, 2'b00, 2'b00);
    chk(0, "rw_frz2", EN_0, RS_ALL, 2'b00, 2'b00);
    rstn = 0;
    chk(0, "rw_rst", EN_0, RS_0, 2'b00, 2'b00);
    rstn = 1; idle();
    chk(0, "rw_run1", EN_ALL, RS_ALL, 2'b00, 2'b00);
    chk(0, "rw_run2", EN_ALL, RS_ALL, 2'b00, 2'b00);

    // FWD_EN = 0 instance
    idle(); rs2_id = 9; u2 = 1; rd_mem = 9; wr_mem = 1; mreq = 1; rs2_ex = 9;
    chk(1, "nf_mem_stall", EN_STL, RS_STL, 2'b00, 2'b00);
    idle();
    chk(1, "nf_clear", EN_ALL, RS_ALL, 2'b00, 2'b00);
    idle(); rd_ex = 6; wr_ex = 1; rs2_id = 6; u2 = 1;
    chk(1, "nf_ex_stall1", EN_STL, RS_STL, 2'b00, 2'b00);
    idle(); rd_mem = 6; wr_mem = 1; rs2_id = 6; u2 = 1;
    chk(1, "nf_ex_stall2", EN_STL, RS_STL, 2'b00, 2'b00);
    idle();
    chk(1, "nf_go", EN_ALL, RS_ALL, 2'b00, 2'b00);
    idle(); pcsel = 1; rd_ex = 6; wr_ex = 1; rs1_id = 6; u1 = 1;
    chk(1, "nf_redirect_wins", EN_ALL, RS_RED, 2'b00, 2'b00);
    idle();
    chk(1, "nf_flush_cnt", EN_ALL, RS_ALL, 2'b00, 2'b00);

    guard = 0;
    while (q.size() > 0 && guard < 20) begin @(posedge clk); guard++; end
    if (q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d responses left unchecked, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", napplied, miscompares);
    $finish;
  end
endmodule
